// File: rtl/address_table_pkg.sv
// Shared types and helpers for the address learning table and its lookup engine.
package address_table_pkg;
  localparam int NUM_ENTRIES = 16;
  localparam int NUM_PORTS   = 4;
  localparam int PORT_W      = $clog2(NUM_PORTS);

  typedef logic [47:0]          mac_addr_t;
  typedef logic [PORT_W-1:0]    port_id_t;
  typedef logic [NUM_PORTS-1:0] port_mask_t;

  // Bit 40 is the I/G bit of the first octet; broadcast is a group address too.
  function automatic logic is_group_mac(mac_addr_t mac);
    return mac[40];
  endfunction

  function automatic port_mask_t flood_mask(port_id_t src);
    port_mask_t m;
    m      = '1;
    m[src] = 1'b0;
    return m;
  endfunction
endpackage

// File: rtl/address_lookup_compare.sv
// Holds the latched lookup key and compares each entry returned by the table
// read port against it.
module lookup_compare #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [47:0]       key_mac,
  input  logic [PORT_W-1:0] key_src,
  input  logic              rd_used,
  input  logic [47:0]       rd_mac,
  input  logic [PORT_W-1:0] rd_port,
  output logic              match,
  output logic              port_ok,
  output logic              filter,
  output logic [PORT_W-1:0] src
);
  import address_table_pkg::*;

  mac_addr_t mac_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_q <= '0;
      src   <= '0;
    end else if (load) begin
      mac_q <= key_mac;
      src   <= key_src;
    end
  end

  assign match   = rd_used && (rd_mac == mac_q);
  assign port_ok = 32'(rd_port) < 32'(NUM_PORTS);
  assign filter  = rd_port == src;
endmodule

// File: rtl/address_lookup.sv
// Destination MAC lookup: sequential scan of the learning table through a
// one-cycle-latency read port, returning an egress mask and a hit report.
module address_lookup #(
  parameter int NUM_ENTRIES = address_table_pkg::NUM_ENTRIES,
  parameter int NUM_PORTS   = 4,
  parameter int IDX_W       = $clog2(NUM_ENTRIES),
  parameter int PORT_W      = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [47:0]          req_dst_mac,
  input  logic [PORT_W-1:0]    req_src_port,
  output logic                 rd_en,
  output logic [IDX_W-1:0]     rd_idx,
  input  logic                 rd_used,
  input  logic [47:0]          rd_mac,
  input  logic [PORT_W-1:0]    rd_port,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [NUM_PORTS-1:0] resp_port_mask,
  output logic                 resp_hit,
  output logic                 hit_valid,
  output logic [IDX_W-1:0]     hit_idx
);
  import address_table_pkg::*;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ENTRIES - 1);

  state_t               state;
  logic                 accept, match, port_ok, filter;
  logic [PORT_W-1:0]    key_src;
  logic                 cmp_vld;
  logic [IDX_W-1:0]     cmp_idx;
  logic [NUM_PORTS-1:0] flood_now, flood_key, hit_mask;

  assign accept    = req_valid && req_ready;
  assign flood_now = ~(NUM_PORTS'(1) << req_src_port);
  assign flood_key = ~(NUM_PORTS'(1) << key_src);
  assign hit_mask  = filter ? '0 : (NUM_PORTS'(1) << rd_port);

  lookup_compare #(.NUM_PORTS(NUM_PORTS), .PORT_W(PORT_W)) u_cmp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .key_mac (req_dst_mac),
    .key_src (req_src_port),
    .rd_used (rd_used),
    .rd_mac  (rd_mac),
    .rd_port (rd_port),
    .match   (match),
    .port_ok (port_ok),
    .filter  (filter),
    .src     (key_src)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_ready      <= 1'b0;
      rd_en          <= 1'b0;
      rd_idx         <= '0;
      cmp_vld        <= 1'b0;
      cmp_idx        <= '0;
      resp_valid     <= 1'b0;
      resp_port_mask <= '0;
      resp_hit       <= 1'b0;
      hit_valid      <= 1'b0;
      hit_idx        <= '0;
    end else begin
      hit_valid <= 1'b0;
      // Read data for the index issued last cycle is on the bus this cycle.
      cmp_vld   <= (state == SCAN) && rd_en;
      cmp_idx   <= rd_idx;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            if (is_group_mac(req_dst_mac)) begin
              state          <= RESP;
              resp_valid     <= 1'b1;
              resp_port_mask <= flood_now;
              resp_hit       <= 1'b0;
            end else begin
              state  <= SCAN;
              rd_en  <= 1'b1;
              rd_idx <= '0;
            end
          end
        end
        SCAN: begin
          if (rd_en) begin
            if (rd_idx == LAST) rd_en <= 1'b0;
            else                rd_idx <= rd_idx + 1'b1;
          end
          // The read in flight when a match lands is simply dropped.
          if (cmp_vld && match) begin
            state          <= RESP;
            rd_en          <= 1'b0;
            resp_valid     <= 1'b1;
            resp_hit       <= port_ok;
            resp_port_mask <= port_ok ? hit_mask : flood_key;
            hit_valid      <= 1'b1;
            hit_idx        <= cmp_idx;
          end else if (cmp_vld && cmp_idx == LAST) begin
            state          <= RESP;
            rd_en          <= 1'b0;
            resp_valid     <= 1'b1;
            resp_hit       <= 1'b0;
            resp_port_mask <= flood_key;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_port_mask <= '0;
            resp_hit       <= 1'b0;
            hit_idx        <= '0;
            rd_idx         <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_address_lookup.sv
// Directed bench for address_lookup: table model, scan-result model and a
// per-cycle compare process, plus literal expectations per lookup.
module tb_address_lookup;
  localparam int N  = 16;
  localparam int NP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [47:0] req_dst_mac = '0;
  logic [1:0]  req_src_port = '0;
  logic        rd_en;
  logic [3:0]  rd_idx;
  logic        rd_used = 1'b0;
  logic [47:0] rd_mac = '0;
  logic [1:0]  rd_port = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [3:0]  resp_port_mask;
  logic        resp_hit;
  logic        hit_valid;
  logic [3:0]  hit_idx;

  always #5 clk = ~clk;

  address_lookup #(.NUM_ENTRIES(N), .NUM_PORTS(NP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_mac(req_dst_mac), .req_src_port(req_src_port),
    .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_used(rd_used), .rd_mac(rd_mac), .rd_port(rd_port),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_port_mask(resp_port_mask), .resp_hit(resp_hit),
    .hit_valid(hit_valid), .hit_idx(hit_idx)
  );

  // Table contents and its one-cycle read port
  logic        t_used [N];
  logic [47:0] t_mac  [N];
  logic [1:0]  t_port [N];

  always @(posedge clk) begin
    if (rd_en) begin
      rd_used <= t_used[rd_idx];
      rd_mac  <= t_mac[rd_idx];
      rd_port <= t_port[rd_idx];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected result of a lookup against the current table contents
  bit         armed = 0, post = 0, m_group, m_hit, m_hv;
  int         t_acc, m_lat;
  logic [3:0] m_mask, m_idx;

  task automatic model(input logic [47:0] mac, input logic [1:0] src);
    m_group = mac[40];
    m_hv    = 0;
    m_hit   = 0;
    m_idx   = '0;
    m_mask  = 4'hF & ~(4'h1 << src);
    m_lat   = m_group ? 1 : 2 + N;
    if (!m_group) begin
      for (int k = 0; k < N; k++) begin
        if (t_used[k] && t_mac[k] == mac) begin
          m_hv   = 1;
          m_hit  = 1;
          m_idx  = 4'(k);
          m_lat  = 3 + k;
          m_mask = (t_port[k] == src) ? 4'h0 : (4'h1 << t_port[k]);
          return;
        end
      end
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n) begin
      if (!armed) begin
        chk("idle_resp_valid", resp_valid, 0);
        chk("idle_hit_valid", hit_valid, 0);
      end else if (post) begin
        chk("post_req_ready", req_ready, 1);
        chk("post_resp_valid", resp_valid, 0);
        chk("post_hit_valid", hit_valid, 0);
        armed = 0;
        post  = 0;
      end else if (cyc > t_acc) begin
        chk("busy_req_ready", req_ready, 0);
        if (m_group) chk("group_rd_en", rd_en, 0);
        if (cyc < t_acc + m_lat) begin
          chk("early_resp_valid", resp_valid, 0);
          chk("early_hit_valid", hit_valid, 0);
        end else begin
          chk("resp_valid", resp_valid, 1);
          chk("resp_mask", resp_port_mask, m_mask);
          chk("resp_hit", resp_hit, m_hit);
          chk("hit_pulse", hit_valid, (cyc == t_acc + m_lat) && m_hv);
          if (hit_valid) chk("hit_idx_model", hit_idx, m_idx);
          if (resp_ready) post = 1;
        end
      end
    end
  end

  task automatic lookup(input logic [47:0] mac, input logic [1:0] src, input int hold,
                        input int x_lat, input logic [3:0] x_mask, input logic x_hit,
                        input logic x_hv, input logic [3:0] x_idx);
    int n;
    @(posedge clk); #1;
    chk("req_ready_idle", req_ready, 1);
    model(mac, src);
    t_acc        = cyc;
    post         = 0;
    armed        = 1;
    req_valid    = 1'b1;
    req_dst_mac  = mac;
    req_src_port = src;
    resp_ready   = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout: no resp_valid for mac %h", mac);
      armed = 0;
      resp_ready = 1'b0;
      return;
    end
    chk("latency", cyc - t_acc, x_lat);
    chk("mask", resp_port_mask, x_mask);
    chk("hit", resp_hit, x_hit);
    chk("hit_valid", hit_valid, x_hv);
    if (x_hv) chk("hit_idx", hit_idx, x_idx);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      resp_ready = 1'b1;
    end
    n = 0;
    while (armed && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (armed) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: response never retired");
      armed = 0;
    end
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      t_used[i] = 1'b1;
      t_mac[i]  = 48'h0200_0000_0000 | 48'(i);
      t_port[i] = 2'(i);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_idx", rd_idx, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mask", resp_port_mask, 0);
    chk("rst_hit", resp_hit, 0);
    chk("rst_hit_valid", hit_valid, 0);
    chk("rst_hit_idx", hit_idx, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_req_ready", req_ready, 1);

    lookup(48'hFFFF_FFFF_FFFF, 2'd2, 0, 1, 4'b1011, 0, 0, 0);

    t_mac[5] = 48'h0011_2233_4455; t_port[5] = 2'd3;
    lookup(48'h0011_2233_4455, 2'd0, 0, 8, 4'b1000, 1, 1, 4'd5);

    t_mac[2] = 48'h00AA_BBCC_DDEE; t_port[2] = 2'd1;
    t_mac[9] = 48'h00AA_BBCC_DDEE; t_port[9] = 2'd2;
    lookup(48'h00AA_BBCC_DDEE, 2'd0, 0, 5, 4'b0010, 1, 1, 4'd2);

    lookup(48'h00DE_ADBE_EF01, 2'd1, 0, 18, 4'b1101, 0, 0, 0);
    t_mac[7] = 48'h00DE_ADBE_EF01; t_used[7] = 1'b0;
    lookup(48'h00DE_ADBE_EF01, 2'd1, 0, 18, 4'b1101, 0, 0, 0);

    t_mac[4] = 48'h0012_3456_789A; t_port[4] = 2'd1;
    lookup(48'h0012_3456_789A, 2'd1, 5, 7, 4'b0000, 1, 1, 4'd4);

    lookup(48'h0100_5E00_0001, 2'd0, 0, 1, 4'b1110, 0, 0, 0);
    lookup(48'h0200_0000_0000, 2'd3, 0, 3, 4'b0001, 1, 1, 4'd0);
    lookup(48'h0200_0000_000F, 2'd0, 0, 18, 4'b1000, 1, 1, 4'd15);

    // Reset in the middle of a scan
    @(posedge clk); #1;
    chk("req_ready_pre_abort", req_ready, 1);
    req_valid    = 1'b1;
    req_dst_mac  = 48'h00DE_ADBE_EF02;
    req_src_port = 2'd1;
    resp_ready   = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("scan_first_rd_en", rd_en, 1);
    chk("scan_first_rd_idx", rd_idx, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("scan_t4_rd_idx", rd_idx, 3);
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", req_ready, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_rd_idx", rd_idx, 0);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_mask", resp_port_mask, 0);
    chk("abort_hit", resp_hit, 0);
    chk("abort_hit_valid", hit_valid, 0);
    chk("abort_hit_idx", hit_idx, 0);
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_rel_req_ready", req_ready, 1);
    repeat (20) @(posedge clk);

    lookup(48'h0011_2233_4455, 2'd0, 0, 8, 4'b1000, 1, 1, 4'd5);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
